// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative radix-2 restoring divider for DIV/DIVU with hi/lo result
`timescale 1ns/1ps
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    counter;
  logic [WIDTH-1:0] rem_q;       // partial remainder, always below the divisor
  logic [WIDTH-1:0] quo_q;       // dividend bits shifted out, quotient bits shifted in
  logic [WIDTH-1:0] dvs_q;       // magnitude of the divisor
  logic             neg_quo;
  logic             neg_rem;

  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] abs_dividend;
  logic [WIDTH-1:0] abs_divisor;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;
  logic             last_iter;

  // Operand magnitudes, one restoring step, and the final sign fix-up.
  // The most-negative value negates to itself and is then read as unsigned.
  always_comb begin
    abs_dividend = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    abs_divisor  = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
    rem_shift    = {rem_q, quo_q[WIDTH-1]};
    trial        = rem_shift - {1'b0, dvs_q};
    quo_fix      = neg_quo ? -quo_q : quo_q;
    rem_fix      = neg_rem ? -rem_q : rem_q;
    last_iter    = (counter == CW'(WIDTH));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= FREE;
    else     state <= state_next;
  end

  // Next-state logic; annul only matters while iterating.
  always_comb begin
    state_next = state;
    case (state)
      FREE:    if (start_i && !annul_i)
                 state_next = (opdata2_i == '0) ? BYZERO : ON;
      BYZERO:  state_next = END;
      ON:      if (annul_i)        state_next = FREE;
               else if (last_iter) state_next = END;
      END:     if (!start_i)       state_next = FREE;
      default: state_next = FREE;
    endcase
  end

  // Datapath and registered outputs; nothing partial ever reaches result_o.
  always_ff @(posedge clk) begin
    if (rst) begin
      counter  <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      neg_quo  <= 1'b0;
      neg_rem  <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      case (state)
        FREE: begin
          result_o <= '0;
          ready_o  <= 1'b0;
          if (start_i && !annul_i && opdata2_i != '0) begin
            quo_q   <= abs_dividend;
            dvs_q   <= abs_divisor;
            rem_q   <= '0;
            counter <= '0;
            neg_quo <= signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            neg_rem <= signed_div_i && opdata1_i[WIDTH-1];
          end
        end
        BYZERO: begin
          result_o <= '0;
          ready_o  <= 1'b1;
        end
        ON: begin
          if (annul_i) begin
            result_o <= '0;
            ready_o  <= 1'b0;
          end else if (last_iter) begin
            result_o <= {rem_fix, quo_fix};
            ready_o  <= 1'b1;
          end else begin
            // A clear borrow bit means the divisor fits: keep the difference.
            if (!trial[WIDTH]) begin
              rem_q <= trial[WIDTH-1:0];
              quo_q <= {quo_q[WIDTH-2:0], 1'b1};
            end else begin
              rem_q <= rem_shift[WIDTH-1:0];
              quo_q <= {quo_q[WIDTH-2:0], 1'b0};
            end
            counter <= counter + 1'b1;
          end
        end
        END: begin
          if (!start_i) begin
            result_o <= '0;
            ready_o  <= 1'b0;
          end
        end
        default: begin
          result_o <= '0;
          ready_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule
